// File: rtl/signed_mult_rr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : signed_mult_rr_scheduler (+ signed_vedic_mult_32bit)            |
// | Desc   : Two-requester round-robin front end for a shared multicycle     |
// |          32x32 signed multiplier with a tagged valid/ready response.     |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+

module signed_vedic_mult_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] p
);
  logic signed [63:0] w_a_ext;
  logic signed [63:0] w_b_ext;

  // Both operands are sign-extended to 64 bits so the low half of the product is exact.
  assign w_a_ext = {{32{a[31]}}, a};
  assign w_b_ext = {{32{b[31]}}, b};
  assign p       = w_a_ext * w_b_ext;
endmodule

module signed_mult_rr_scheduler #(
  parameter int CALC_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_out,
  output logic        rsp_id,
  output logic        busy
);
  localparam logic [1:0]       c_s_idle   = 2'd0;
  localparam logic [1:0]       c_s_calc   = 2'd1;
  localparam logic [1:0]       c_s_done   = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(CALC_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_id;
  logic             r_ptr;
  logic             r_rsp_valid;
  logic [63:0]      r_rsp_out;
  logic             r_rsp_id;

  logic             w_grant;
  logic             w_any;
  logic             w_xfer;
  logic             w_cnt_zero;
  logic [63:0]      w_product;

  // r_ptr = 0 favours req0; only consulted when both requesters are valid.
  assign w_any      = req0_valid | req1_valid;
  assign w_grant    = (req0_valid & req1_valid) ? r_ptr : req1_valid;
  assign w_xfer     = (r_state == c_s_idle) & w_any;
  assign w_cnt_zero = (r_cnt == '0);

  signed_vedic_mult_32bit u_mult (
    .a (r_op_a),
    .b (r_op_b),
    .p (w_product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_s_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_s_idle: if (w_xfer)     w_state_nxt = c_s_calc;
      c_s_calc: if (w_cnt_zero) w_state_nxt = c_s_done;
      c_s_done: if (rsp_ready)  w_state_nxt = c_s_idle;
      default:                  w_state_nxt = c_s_idle;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = (r_state != c_s_idle);
    if (r_state == c_s_idle) begin
      req0_ready = req0_valid & ~w_grant;
      req1_ready = req1_valid &  w_grant;
    end
  end

  // Operands are captured only through the grant mux, so an idle requester's data never reaches the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_id        <= 1'b0;
      r_ptr       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_out   <= '0;
      r_rsp_id    <= 1'b0;
    end else begin
      case (r_state)
        c_s_idle: begin
          if (w_xfer) begin
            r_op_a <= w_grant ? req1_a : req0_a;
            r_op_b <= w_grant ? req1_b : req0_b;
            r_id   <= w_grant;
            r_ptr  <= ~w_grant;
            r_cnt  <= c_cnt_load;
          end
        end
        c_s_calc: begin
          if (w_cnt_zero) begin
            r_rsp_out   <= w_product;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - c_cnt_one;
          end
        end
        c_s_done: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_out   = r_rsp_out;
  assign rsp_id    = r_rsp_id;
endmodule

`default_nettype wire

// File: tb/tb_signed_mult_rr_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_signed_mult_rr_scheduler                                     |
// | Desc   : Directed and randomized self-checking bench for the scheduler.  |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_signed_mult_rr_scheduler;
  localparam int CALC_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [63:0] rsp_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_ptr;

  signed_mult_rr_scheduler #(.CALC_CYCLES(CALC_CYCLES), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out), .rsp_id(rsp_id),
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Mathematical 64-bit signed product.
  function automatic logic [63:0] exp_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    tick; tick;
    rst = 1'b0;
    exp_ptr = 1'b0;
  endtask

  // Present one request and wait (bounded) for its accept edge; returns just after it.
  task automatic send(input bit id, input logic [31:0] a, input logic [31:0] b, output bit ok);
    ok = 1'b0;
    if (id == 1'b0) begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    else            begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    for (int i = 0; i < 30 && !ok; i++) begin
      #1;
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) ok = 1'b1;
      else tick;
    end
    if (ok) tick;
    if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, then consume it with rsp_ready high.
  task automatic recv(output bit ok, output logic [63:0] out, output bit id, output int lat);
    ok = 1'b0; lat = 0; out = '0; id = 1'b0;
    rsp_ready = 1'b1;
    while (!rsp_valid && lat < 50) begin tick; lat++; end
    if (rsp_valid) begin
      ok = 1'b1; out = rsp_out; id = rsp_id;
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    tick;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    n_checks++; if (rsp_out !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_out: got %h expected 0", rsp_out); end
    n_checks++; if (rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0; rsp_ready = 1'b1;
    tick;
    n_checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin n_fail++; $display("FAIL idle_no_valid_ready: got %b%b expected 00", req0_ready, req1_ready); end
  endtask

  task automatic test_basic;
    bit ok, id; logic [63:0] out; int lat;
    do_reset;
    send(1'b0, 32'h2, 32'h3, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_accept0: got timeout expected ready"); end
    n_checks++; if (busy !== 1'b1 || req0_ready !== 1'b0) begin n_fail++; $display("FAIL basic_calc_state: got busy=%b ready=%b expected busy=1 ready=0", busy, req0_ready); end
    recv(ok, out, id, lat);
    n_checks++; if (!ok || out !== 64'h6 || id !== 1'b0) begin n_fail++; $display("FAIL basic_2x3: got %h id %b expected 6 id 0", out, id); end
    n_checks++; if (lat != CALC_CYCLES) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, CALC_CYCLES); end
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_back_idle: got valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    send(1'b1, 32'hFFFFFFFE, 32'h3, ok);
    recv(ok, out, id, lat);
    n_checks++; if (!ok || out !== 64'hFFFFFFFFFFFFFFFA || id !== 1'b1) begin n_fail++; $display("FAIL basic_neg2x3: got %h id %b expected fffffffffffffffa id 1", out, id); end
    send(1'b0, 32'hFFFFFFFE, 32'hFFFFFFFD, ok);
    recv(ok, out, id, lat);
    n_checks++; if (!ok || out !== 64'h6 || id !== 1'b0) begin n_fail++; $display("FAIL basic_neg2xneg3: got %h id %b expected 6 id 0", out, id); end
  endtask

  task automatic test_fairness;
    int g[$]; logic [63:0] r[$]; bit rid[$];
    bit ok, id; logic [63:0] out; int lat;
    do_reset;
    req0_valid = 1'b1; req0_a = 32'h2; req0_b = 32'hFFFFFFFD;
    req1_valid = 1'b1; req1_a = 32'h5; req1_b = 32'h7;
    for (int c = 0; c < 40 && g.size() < 3; c++) begin
      #1;
      n_checks++; if (req0_ready && req1_ready) begin n_fail++; $display("FAIL fair_both_ready: got 11 expected at most one"); end
      if (req0_ready) g.push_back(0); else if (req1_ready) g.push_back(1);
      if (rsp_valid) begin r.push_back(rsp_out); rid.push_back(rsp_id); end
      tick;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++;
    if (g.size() != 3) begin n_fail++; $display("FAIL fair_grant_count: got %0d expected 3", g.size()); end
    else if (g[0] != 0 || g[1] != 1 || g[2] != 0) begin n_fail++; $display("FAIL fair_order: got %0d%0d%0d expected 010", g[0], g[1], g[2]); end
    n_checks++;
    if (r.size() != 2) begin n_fail++; $display("FAIL fair_rsp_count: got %0d expected 2", r.size()); end
    else if (r[0] !== 64'hFFFFFFFFFFFFFFFA || rid[0] !== 1'b0 || r[1] !== 64'h23 || rid[1] !== 1'b1)
      begin n_fail++; $display("FAIL fair_rsp: got %h/%b %h/%b expected fffffffffffffffa/0 23/1", r[0], rid[0], r[1], rid[1]); end
    recv(ok, out, id, lat);
    n_checks++; if (!ok || out !== 64'hFFFFFFFFFFFFFFFA || id !== 1'b0) begin n_fail++; $display("FAIL fair_third: got %h id %b expected fffffffffffffffa id 0", out, id); end
  endtask

  task automatic test_backpressure;
    bit ok, id; logic [63:0] out; int lat;
    do_reset;
    rsp_ready = 1'b0;
    send(1'b0, 32'h3, 32'h4, ok);
    lat = 0;
    while (!rsp_valid && lat < 50) begin tick; lat++; end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", rsp_valid); end
    req1_valid = 1'b1; req1_a = 32'h9; req1_b = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_out !== 64'hC || rsp_id !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold: got v=%b out=%h id=%b r1=%b busy=%b expected 1 c 0 0 1", rsp_valid, rsp_out, rsp_id, req1_ready, busy);
      end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req1_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b busy=%b r1=%b expected 0 0 1", rsp_valid, busy, req1_ready); end
    n_checks++; if (rsp_out !== 64'hC) begin n_fail++; $display("FAIL bp_out_kept: got %h expected c", rsp_out); end
    send(1'b1, 32'h9, 32'hFFFFFFFF, ok);
    recv(ok, out, id, lat);
    n_checks++; if (!ok || out !== 64'hFFFFFFFFFFFFFFF7 || id !== 1'b1) begin n_fail++; $display("FAIL bp_next: got %h id %b expected fffffffffffffff7 id 1", out, id); end
  endtask

  task automatic test_extremes;
    bit ok, id; logic [63:0] out; int lat;
    do_reset;
    send(1'b0, 32'h80000000, 32'h80000000, ok);
    recv(ok, out, id, lat);
    n_checks++; if (!ok || out !== 64'h4000000000000000) begin n_fail++; $display("FAIL ext_min_min: got %h expected 4000000000000000", out); end
    send(1'b0, 32'h7FFFFFFF, 32'h80000000, ok);
    recv(ok, out, id, lat);
    n_checks++; if (!ok || out !== 64'hC000000080000000) begin n_fail++; $display("FAIL ext_max_min: got %h expected c000000080000000", out); end
  endtask

  task automatic test_reset_mid_calc;
    bit ok, id; logic [63:0] out; int lat;
    bit seen;
    do_reset;
    send(1'b1, 32'h9, 32'h9, ok);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmc_calc: got busy=%b expected 1", busy); end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmc_async: got busy=%b valid=%b expected 0 0", busy, rsp_valid); end
    tick;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick; if (rsp_valid) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL rmc_no_rsp: got response expected none"); end
    req1_valid = 1'b1; req1_a = 32'h4; req1_b = 32'h4;
    send(1'b0, 32'h2, 32'h3, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rmc_ptr: got req1 grant or timeout expected req0 grant"); end
    req1_valid = 1'b0;
    recv(ok, out, id, lat);
    n_checks++; if (!ok || out !== 64'h6 || id !== 1'b0) begin n_fail++; $display("FAIL rmc_after: got %h id %b expected 6 id 0", out, id); end
  endtask

  task automatic test_random;
    logic [1:0]  v;
    logic [31:0] a0, b0, a1, b1;
    logic [63:0] exp_p, held;
    bit          eg;
    int          lat, k;
    do_reset;
    for (int t = 0; t < 40; t++) begin
      v  = 2'($urandom_range(1, 3));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      req0_valid = v[0]; req0_a = a0; req0_b = b0;
      req1_valid = v[1]; req1_a = a1; req1_b = b1;
      eg    = (v == 2'b11) ? exp_ptr : v[1];
      exp_p = eg ? exp_mul(a1, b1) : exp_mul(a0, b0);
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (req0_ready !== (eg == 1'b0) || req1_ready !== (eg == 1'b1)) begin
        n_fail++; $display("FAIL rnd_grant[%0d]: got %b%b expected grant %0d", t, req0_ready, req1_ready, eg);
      end
      tick;
      exp_ptr = ~eg;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = $urandom; req1_a = $urandom;
      lat = 0;
      while (!rsp_valid && lat < 50) begin tick; lat++; end
      n_checks++; if (lat != CALC_CYCLES) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", t, lat, CALC_CYCLES); end
      held = rsp_out;
      if (!rsp_ready) begin
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) tick;
        n_checks++; if (rsp_valid !== 1'b1 || rsp_out !== held) begin n_fail++; $display("FAIL rnd_stall[%0d]: got v=%b out=%h expected 1 %h", t, rsp_valid, rsp_out, held); end
        rsp_ready = 1'b1;
      end
      n_checks++;
      if (rsp_out !== exp_p || rsp_id !== eg) begin
        n_fail++; $display("FAIL rnd_product[%0d]: got %h id %b expected %h id %b", t, rsp_out, rsp_id, exp_p, eg);
      end
      tick;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_consume[%0d]: got %b expected 0", t, rsp_valid); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fairness;
    test_backpressure;
    test_extremes;
    test_reset_mid_calc;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/signed_mult_rr_scheduler.md
Name: signed_mult_rr_scheduler

Overview:
- Shares one combinational signed_vedic_mult_32bit instance between two requesters using round-robin arbitration.
- Registers the granted operands and holds them stable for a programmable number of settle cycles. This makes the multiplier a multicycle path.
- Registers the 64-bit signed product and presents it on a valid/ready response channel tagged with the requester ID.
- Sits between the client datapaths and the multiplier core in the 64-bit build.

Parameters:
- CALC_CYCLES, 2, number of clock cycles operands are held before the product is sampled (legal range 1..15).
- CNT_W, 4, width of the settle counter (must satisfy 2^CNT_W > CALC_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req0_valid  input  1  requester 0 has an operand pair.
- req0_ready  output  1  requester 0 pair accepted this cycle.
- req0_a  input  32  requester 0 multiplicand, two's complement.
- req0_b  input  32  requester 0 multiplier, two's complement.
- req1_valid  input  1  requester 1 has an operand pair.
- req1_ready  output  1  requester 1 pair accepted this cycle.
- req1_a  input  32  requester 1 multiplicand, two's complement.
- req1_b  input  32  requester 1 multiplier, two's complement.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts product.
- rsp_out  output  64  signed product.
- rsp_id  output  1  ID of the requester that owns rsp_out.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- One clock, clk. rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_out=0, rsp_id=0, busy=0.
  - Counter=0, operand registers=0.
  - Priority pointer favours req0.
- FSM states: IDLE, CALC, DONE.
- IDLE, grant rule:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the one the pointer favours.
- IDLE, handshake:
  - reqN_ready is combinational: high only in IDLE, and only for the granted N.
  - The transfer occurs on the edge where reqN_valid && reqN_ready are both high.
- IDLE, on transfer:
  - Capture a/b into op_a/op_b and N into id_r.
  - Load counter with CALC_CYCLES-1, go to CALC.
  - Set the pointer to favour the other requester.
- IDLE with no valid: stay in IDLE, both readys low.
- CALC:
  - op_a/op_b drive the multiplier and stay unchanged.
  - Counter decrements each cycle.
  - On the cycle where counter==0, register the multiplier output into rsp_out and id_r into rsp_id. Set rsp_valid=1 and go to DONE.
  - CALC therefore lasts exactly CALC_CYCLES cycles.
- DONE:
  - rsp_valid=1. rsp_out and rsp_id are held stable until the handshake.
  - When rsp_ready=1: clear rsp_valid and go to IDLE on that edge. rsp_out keeps its last value.
  - When rsp_ready=0: stay in DONE indefinitely. No new request is accepted; both readys stay low.
- Latency: rsp_valid rises CALC_CYCLES edges after the accept edge.
  - With rsp_ready tied high, back-to-back issue is one op per CALC_CYCLES+2 cycles.
- Requester rules:
  - A requester must hold valid, a and b stable until it sees ready.
  - Changes while un-granted are legal and have no effect.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...
- Arithmetic: rsp_out is the full 64-bit two's-complement product of op_a×op_b, with no truncation or saturation.
  - Example: 0x80000000×0x80000000 = 0x4000000000000000.
- busy = (state != IDLE).
- Reset asserted mid-CALC or mid-DONE:
  - The in-flight operation is discarded and no response is issued.
  - All registers return to reset values immediately. Reset is asynchronous and does not wait for a clock edge.
- X on an un-granted requester's data must never propagate to rsp_out.

Test Plan:
1. req0 a=0x00000002, b=0x00000003, rsp_ready=1, CALC_CYCLES=2 -> req0_ready high one cycle; rsp_valid 2 edges later; rsp_out=0x0000000000000006, rsp_id=0.
2. req1 a=0xFFFFFFFE, b=0x00000003 -> rsp_out=0xFFFFFFFFFFFFFFFA, rsp_id=1. Then req0 a=0xFFFFFFFE, b=0xFFFFFFFD -> rsp_out=0x0000000000000006.
3. After reset, req0 and req1 both valid continuously with distinct operands (2×0xFFFFFFFD and 5×7) -> responses are req0 first (0xFFFFFFFFFFFFFFFA), then req1 (0x23); the next grant goes back to req0.
4. Backpressure: rsp_ready=0 for 5 cycles in DONE with req1 valid -> rsp_valid/rsp_out/rsp_id stable and req1_ready=0 throughout. rsp_ready=1 -> IDLE next edge, then req1 accepted.
5. Extremes: a=b=0x80000000 -> 0x4000000000000000. a=0x7FFFFFFF, b=0x80000000 -> 0xC000000080000000.
6. Assert rst for 1 cycle mid-CALC -> rsp_valid stays 0, busy=0 immediately, no response for the aborted op. A subsequent 2×3 request yields 6 with the pointer favouring req0.
